// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Constants and types shared by the 7x7 / 3x3 serial
//                convolution engine, its stream feeder and their benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  // Geometry of one tile: 7x7 input, 3x3 kernel, 5x5 valid output.
  localparam int ROW_STRIDE = 7;
  localparam int KER_DIM    = 3;
  localparam int OUT_DIM    = ROW_STRIDE - KER_DIM + 1;

  localparam int IFM_W = 16;
  localparam int OFM_W = 36;
  localparam int N_IFM = ROW_STRIDE * ROW_STRIDE;
  localparam int N_W   = KER_DIM * KER_DIM;
  localparam int N_OFM = OUT_DIM * OUT_DIM;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_result_buffer
//  Description : Result register file, one write port, one combinational
//                read port and a synchronous clear of every entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_result_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = N_OFM,
  parameter int WIDTH = OFM_W,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage: clear wipes all entries, otherwise accept in-range writes.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr < AW'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: addresses past the end of the array read as zero.
  always_comb begin
    rdata = '0;
    if (raddr < AW'(DEPTH)) begin
      rdata = mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : conv_stream_feeder
//  Description : Holds one IFM tile and kernel written by the host, streams
//                them into the convolution engine on start, then collects
//                the engine's result burst into a host-readable buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_stream_feeder #(
  parameter int IFM_W   = conv_pkg::IFM_W,
  parameter int OFM_W   = conv_pkg::OFM_W,
  parameter int N_IFM   = conv_pkg::N_IFM,
  parameter int N_W     = conv_pkg::N_W,
  parameter int N_OFM   = conv_pkg::N_OFM,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [5:0]       cfg_addr,
  input  logic [IFM_W-1:0] cfg_wdata,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             in_valid,
  output logic             weight_valid,
  output logic [IFM_W-1:0] In_IFM_1,
  output logic [IFM_W-1:0] In_Weight_1,
  input  logic             out_valid,
  input  logic [OFM_W-1:0] Out_OFM,
  input  logic [4:0]       res_addr,
  output logic [OFM_W-1:0] res_data,
  output logic [4:0]       res_count
);

  import conv_pkg::*;

  localparam int IFM_AW = $clog2(N_IFM);
  localparam int W_AW   = $clog2(N_W);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [5:0]        LAST_IDX  = 6'(N_IFM - 1);
  localparam logic [5:0]        IFM_LIM   = 6'(N_IFM);
  localparam logic [5:0]        W_LIM     = 6'(N_W);
  localparam logic [4:0]        LAST_RES  = 5'(N_OFM - 1);
  localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(TIMEOUT - 1);

  feeder_state_t     state;
  logic [IFM_W-1:0]  ifm_mem [N_IFM];
  logic [IFM_W-1:0]  w_mem   [N_W];
  logic [5:0]        idx;        // index of the word currently on the stream
  logic [5:0]        nxt_idx;
  logic [IDLE_W-1:0] idle_cnt;
  logic              cfg_ok;
  logic              cap_we;
  logic [OFM_W-1:0]  buf_rdata;

  assign nxt_idx = idx + 6'd1;
  // Host writes only land while idle and not in the same cycle as a launch.
  assign cfg_ok  = cfg_we && !start && (state == ST_IDLE);
  assign cap_we  = (state == ST_COLLECT) && out_valid;
  // Entries beyond the current capture count are hidden from the host.
  assign res_data = (res_addr < res_count) ? buf_rdata : '0;

  // Config buffers: cleared by reset, written by the host port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IFM; i++) ifm_mem[i] <= '0;
      for (int j = 0; j < N_W; j++)   w_mem[j]   <= '0;
    end else if (cfg_ok) begin
      if (!cfg_sel && (cfg_addr < IFM_LIM)) ifm_mem[cfg_addr[IFM_AW-1:0]] <= cfg_wdata;
      if (cfg_sel && (cfg_addr < W_LIM))    w_mem[cfg_addr[W_AW-1:0]]     <= cfg_wdata;
    end
  end

  // Sequencer: send the tile, collect the results, pulse done; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      idle_cnt     <= '0;
      res_count    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      in_valid     <= 1'b0;
      weight_valid <= 1'b0;
      In_IFM_1     <= '0;
      In_Weight_1  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_SEND;
            idx          <= '0;
            idle_cnt     <= '0;
            res_count    <= '0;
            timeout_err  <= 1'b0;
            busy         <= 1'b1;
            in_valid     <= 1'b1;
            In_IFM_1     <= ifm_mem[0];
            weight_valid <= 1'b1;
            In_Weight_1  <= w_mem[0];
          end
        end
        ST_SEND: begin
          if (idx == LAST_IDX) begin
            state        <= ST_COLLECT;
            in_valid     <= 1'b0;
            weight_valid <= 1'b0;
            In_IFM_1     <= '0;
            In_Weight_1  <= '0;
          end else begin
            idx      <= nxt_idx;
            In_IFM_1 <= ifm_mem[nxt_idx[IFM_AW-1:0]];
            // Kernel rides alongside the first N_W IFM words.
            if (nxt_idx < W_LIM) begin
              weight_valid <= 1'b1;
              In_Weight_1  <= w_mem[nxt_idx[W_AW-1:0]];
            end else begin
              weight_valid <= 1'b0;
              In_Weight_1  <= '0;
            end
          end
        end
        ST_COLLECT: begin
          if (out_valid) begin
            res_count <= res_count + 5'd1;
            idle_cnt  <= '0;
            if (res_count == LAST_RES) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else if (idle_cnt == LAST_IDLE) begin
            // Engine went quiet too long; keep whatever was captured.
            timeout_err <= 1'b1;
            state       <= ST_DONE;
            done        <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  conv_result_buffer #(
    .DEPTH (N_OFM),
    .WIDTH (OFM_W),
    .AW    (5)
  ) u_res_buf (
    .clk   (clk),
    .clr   (rst),
    .we    (cap_we),
    .waddr (res_count),
    .wdata (Out_OFM),
    .raddr (res_addr),
    .rdata (buf_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_stream_feeder
//  Description : Self-checking bench for conv_stream_feeder with a small
//                convolution engine model and queue-based scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_stream_feeder;
  import conv_pkg::*;

  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic             cfg_sel = 1'b0;
  logic [5:0]       cfg_addr = '0;
  logic [IFM_W-1:0] cfg_wdata = '0;
  logic             start = 1'b0;
  logic             busy, done, timeout_err, in_valid, weight_valid;
  logic [IFM_W-1:0] In_IFM_1, In_Weight_1;
  logic             out_valid = 1'b0;
  logic [OFM_W-1:0] Out_OFM = '0;
  logic [4:0]       res_addr = '0;
  logic [OFM_W-1:0] res_data;
  logic [4:0]       res_count;

  always #5 clk = ~clk;

  conv_stream_feeder #(
    .IFM_W(IFM_W), .OFM_W(OFM_W), .N_IFM(N_IFM), .N_W(N_W), .N_OFM(N_OFM), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .in_valid(in_valid), .weight_valid(weight_valid),
    .In_IFM_1(In_IFM_1), .In_Weight_1(In_Weight_1), .out_valid(out_valid),
    .Out_OFM(Out_OFM), .res_addr(res_addr), .res_data(res_data), .res_count(res_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int seen     = 0;

  logic [IFM_W-1:0] ifm_m [N_IFM];
  logic [IFM_W-1:0] w_m   [N_W];
  logic [OFM_W-1:0] res_m [N_OFM];
  logic [IFM_W-1:0] ifm_q [$];
  logic [IFM_W-1:0] w_q   [$];
  logic [OFM_W-1:0] res_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference 3x3 valid convolution over the shadow tile.
  function automatic void calc_model();
    for (int r = 0; r < N_OFM; r++) begin
      longint acc;
      int row, col;
      acc = 0;
      row = r / OUT_DIM;
      col = r % OUT_DIM;
      for (int ki = 0; ki < KER_DIM; ki++)
        for (int kj = 0; kj < KER_DIM; kj++)
          acc += longint'(ifm_m[(row + ki) * ROW_STRIDE + col + kj]) * longint'(w_m[ki * KER_DIM + kj]);
      res_m[r] = OFM_W'(acc);
    end
  endfunction

  task automatic cfg_write(input logic sel, input int addr, input logic [IFM_W-1:0] data);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 6'(addr); cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (!sel && addr < N_IFM) ifm_m[addr] = data;
    if (sel && addr < N_W) w_m[addr] = data;
  endtask

  // Stream monitor: every valid word must match the next scoreboard entry.
  always @(negedge clk) begin
    if (in_valid) begin
      check("ifm_avail", ifm_q.size() > 0, 1'b1);
      if (ifm_q.size() > 0) check("ifm_word", In_IFM_1, ifm_q.pop_front());
      check("w_window", weight_valid, seen < N_W);
      if (weight_valid) begin
        check("w_avail", w_q.size() > 0, 1'b1);
        if (w_q.size() > 0) check("w_word", In_Weight_1, w_q.pop_front());
      end else begin
        check("w_zero", In_Weight_1, 0);
      end
      seen++;
    end
  end

  // mode: 0 plain, 1 cfg write during SEND, 2 start during COLLECT, 3 reset mid-stream
  task automatic run_tile(input int nres, input int mode);
    int n;
    int gap;
    logic [OFM_W-1:0] e;
    calc_model();
    ifm_q.delete(); w_q.delete(); res_q.delete();
    for (int i = 0; i < N_IFM; i++) ifm_q.push_back(ifm_m[i]);
    for (int j = 0; j < N_W; j++) w_q.push_back(w_m[j]);
    seen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("busy_start", busy, 1'b1);
    check("res_count_clr", res_count, 0);
    check("terr_clr", timeout_err, 1'b0);
    n = 0;
    while (in_valid && n < 100) begin
      n++;
      @(posedge clk); #1;
      cfg_we = (mode == 1 && n == 5); cfg_sel = 1'b0; cfg_addr = 6'd3; cfg_wdata = 16'hBEEF;
      rst    = (mode == 3 && n == 21);
      @(negedge clk);
    end
    cfg_we = 1'b0;
    if (mode == 3) begin
      check("rst_in_valid", in_valid, 1'b0);
      check("rst_w_valid", weight_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_res_count", res_count, 0);
      for (int a = 0; a < 32; a++) begin
        res_addr = 5'(a); #1;
        check("rst_res_data", res_data, 0);
      end
      for (int i = 0; i < N_IFM; i++) ifm_m[i] = '0;
      for (int j = 0; j < N_W; j++) w_m[j] = '0;
      ifm_q.delete(); w_q.delete();
      return;
    end
    check("in_valid_len", n, N_IFM);
    check("ifm_q_empty", ifm_q.size(), 0);
    check("w_q_empty", w_q.size(), 0);
    // Engine model: return nres results with short idle gaps.
    for (int r = 0; r < nres; r++) begin
      gap = (r == 0 && nres < N_OFM) ? 50 : ((mode == 2 && r == 2) ? 2 : int'($urandom_range(0, 3)));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        out_valid = 1'b0;
        start = (mode == 2 && r == 2);
      end
      @(posedge clk); #1;
      start = 1'b0; out_valid = 1'b1; Out_OFM = res_m[r];
      res_q.push_back(res_m[r]);
    end
    // Surplus engine traffic after the last result must be ignored.
    @(posedge clk); #1;
    out_valid = (nres == N_OFM); Out_OFM = '1;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk); #1 out_valid = 1'b0;
      n++;
    end
    check("done_lat", n, (nres == N_OFM) ? 1 : TIMEOUT + 1);
    check("busy_at_done", busy, 1'b1);
    @(posedge clk); #1 out_valid = 1'b0;
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("busy_end", busy, 1'b0);
    check("res_count", res_count, nres);
    check("timeout_err", timeout_err, nres < N_OFM);
    for (int a = 0; a < 32; a++) begin
      res_addr = 5'(a); #1;
      e = '0;
      if (a < nres && res_q.size() > 0) e = res_q.pop_front();
      check("res_data", res_data, e);
    end
  endtask

  initial begin
    for (int i = 0; i < N_IFM; i++) ifm_m[i] = '0;
    for (int j = 0; j < N_W; j++) w_m[j] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_terr", timeout_err, 1'b0);
    check("reset_in_valid", in_valid, 1'b0);
    check("reset_w_valid", weight_valid, 1'b0);
    check("reset_ifm", In_IFM_1, 0);
    check("reset_w", In_Weight_1, 0);
    check("reset_res_count", res_count, 0);
    check("reset_res_data", res_data, 0);

    // Load and send: IFM = 1..49, unit kernel.
    for (int i = 0; i < N_IFM; i++) cfg_write(1'b0, i, 16'(i + 1));
    for (int j = 0; j < N_W; j++) cfg_write(1'b1, j, 16'd1);
    run_tile(N_OFM, 0);

    // All-ones loop through the engine, with a stray start during COLLECT.
    for (int i = 0; i < N_IFM; i++) cfg_write(1'b0, i, 16'd1);
    run_tile(N_OFM, 2);

    // Random tile, dropped out-of-range writes, write during SEND, timeout.
    for (int i = 0; i < N_IFM; i++) cfg_write(1'b0, i, 16'($urandom));
    for (int j = 0; j < N_W; j++) cfg_write(1'b1, j, 16'($urandom_range(0, 255)));
    cfg_write(1'b0, 3, 16'h1234);
    cfg_write(1'b0, 50, 16'hDEAD);
    cfg_write(1'b1, 17, 16'hDEAD);
    run_tile(10, 1);
    run_tile(N_OFM, 0);

    // Reset mid-stream, then buffers stream zeros, then a fresh tile.
    run_tile(0, 3);
    run_tile(N_OFM, 0);
    for (int i = 0; i < N_IFM; i++) cfg_write(1'b0, i, 16'($urandom));
    for (int j = 0; j < N_W; j++) cfg_write(1'b1, j, 16'($urandom));
    run_tile(N_OFM, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
